// File: rtl/hit_game_pkg.sv
// Shared definitions for the hit-or-miss game sequencer.
// Holds the FSM state type, the LFSR seed and tap mask, and the difficulty
// encoding that must agree with the frequency divider's select decode.
package hit_game_pkg;

  // Difficulty select width and fastest code understood by the divider.
  localparam int unsigned DIFF_W   = 3;
  localparam int unsigned DIFF_MAX = 4;

  // 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1 -> feedback from bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SHOW,
    OVER
  } game_state_e;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, shifting left with feedback into bit 0.
// Ports:
//   clk  system clock
//   rst  asynchronous active-low reset, loads LFSR_SEED
//   q    current LFSR state
module lfsr8
  import hit_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = {q_q[6:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= LFSR_SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hit_game_ctrl.sv
// Game sequencer for the hit-or-miss randomizer.
// Lights a pseudo-random lamp on each pace tick, judges button hits inside a
// tick-counted window, keeps score and lives, and raises the divider's
// difficulty every HITS_PER_LEVEL correct hits.
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   start       1-cycle pulse, begins a game from IDLE or OVER
//   tick        1-cycle pace strobe from the frequency divider
//   hit         one-hot button pulses (debounced upstream)
//   difficulty  level to the frequency divider, 0..MAX_LEVEL
//   target      index of the lit lamp
//   target_vld  lamp lit / window open
//   score       correct hits this game, saturating
//   lives       remaining lives
//   level_up    1-cycle pulse when difficulty increments
//   game_over   high in OVER until the next start
module hit_game_ctrl
  import hit_game_pkg::*;
#(
  parameter int unsigned HITS_PER_LEVEL = 4,
  parameter int unsigned MAX_LEVEL      = DIFF_MAX,
  parameter int unsigned LIVES          = 3,
  parameter int unsigned WINDOW_TICKS   = 2,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [3:0]         hit,
  output logic [DIFF_W-1:0]  difficulty,
  output logic [1:0]         target,
  output logic               target_vld,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               level_up,
  output logic               game_over
);

  localparam int unsigned HitCntW = (HITS_PER_LEVEL > 1) ? $clog2(HITS_PER_LEVEL) : 1;

  game_state_e        state_q, state_d;
  logic [DIFF_W-1:0]  diff_q, diff_d;
  logic [1:0]         target_q, target_d;
  logic               vld_q, vld_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [2:0]         lives_q, lives_d;
  logic               level_up_q, level_up_d;
  logic               over_q, over_d;
  logic [HitCntW-1:0] hit_cnt_q, hit_cnt_d;
  logic [3:0]         win_cnt_q, win_cnt_d;
  logic               miss;

  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  // Only the low two bits pick a lamp.
  assign unused_lfsr = ^lfsr_q[7:2];

  always_comb begin
    state_d    = state_q;
    diff_d     = diff_q;
    target_d   = target_q;
    vld_d      = vld_q;
    score_d    = score_q;
    lives_d    = lives_q;
    level_up_d = 1'b0;
    over_d     = over_q;
    hit_cnt_d  = hit_cnt_q;
    win_cnt_d  = win_cnt_q;
    miss       = 1'b0;

    case (state_q)
      IDLE, OVER: begin
        if (start) begin
          score_d   = '0;
          lives_d   = 3'(LIVES);
          diff_d    = '0;
          hit_cnt_d = '0;
          over_d    = 1'b0;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (tick) begin
          target_d  = lfsr_q[1:0];
          vld_d     = 1'b1;
          win_cnt_d = 4'(WINDOW_TICKS);
          state_d   = SHOW;
        end
      end
      SHOW: begin
        // A button press takes priority over a coincident window tick.
        if (hit != 4'b0000) begin
          vld_d   = 1'b0;
          state_d = WAIT;
          if (hit == (4'b0001 << target_q)) begin
            if (score_q != {SCORE_W{1'b1}}) begin
              score_d = score_q + SCORE_W'(1);
            end
            if (hit_cnt_q == HitCntW'(HITS_PER_LEVEL - 1)) begin
              hit_cnt_d = '0;
              if (diff_q < DIFF_W'(MAX_LEVEL)) begin
                diff_d     = diff_q + DIFF_W'(1);
                level_up_d = 1'b1;
              end
            end else begin
              hit_cnt_d = hit_cnt_q + HitCntW'(1);
            end
          end else begin
            miss = 1'b1;
          end
        end else if (tick) begin
          win_cnt_d = win_cnt_q - 4'd1;
          if (win_cnt_q == 4'd1) begin
            miss = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (miss) begin
      vld_d = 1'b0;
      if (lives_q == 3'd1) begin
        lives_d = 3'd0;
        over_d  = 1'b1;
        state_d = OVER;
      end else begin
        lives_d = lives_q - 3'd1;
        state_d = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      diff_q     <= '0;
      target_q   <= '0;
      vld_q      <= 1'b0;
      score_q    <= '0;
      lives_q    <= '0;
      level_up_q <= 1'b0;
      over_q     <= 1'b0;
      hit_cnt_q  <= '0;
      win_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      diff_q     <= diff_d;
      target_q   <= target_d;
      vld_q      <= vld_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      level_up_q <= level_up_d;
      over_q     <= over_d;
      hit_cnt_q  <= hit_cnt_d;
      win_cnt_q  <= win_cnt_d;
    end
  end

  assign difficulty = diff_q;
  assign target     = target_q;
  assign target_vld = vld_q;
  assign score      = score_q;
  assign lives      = lives_q;
  assign level_up   = level_up_q;
  assign game_over  = over_q;

endmodule

// File: tb/tb_hit_game_ctrl.sv
// Self-checking bench for hit_game_ctrl: a vector table for the main game
// flow plus hand sequences for level progression and mid-game reset.
module tb_hit_game_ctrl;

  typedef enum logic [1:0] {HN, HOK, HWR, HMU} hk_e;

  typedef struct {
    logic       start;
    logic       tick;
    hk_e        hk;
    logic       vld;
    logic [7:0] score;
    logic [2:0] lives;
    logic [2:0] diff;
    logic       lu;
    logic       over;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] hit = 4'b0000;
  logic [2:0] difficulty;
  logic [1:0] target;
  logic       target_vld;
  logic [7:0] score;
  logic [2:0] lives;
  logic       level_up;
  logic       game_over;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_lfsr;
  logic [1:0] exp_tgt = 2'd0;
  logic       prev_vld = 1'b0;

  hit_game_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tick       (tick),
    .hit        (hit),
    .difficulty (difficulty),
    .target     (target),
    .target_vld (target_vld),
    .score      (score),
    .lives      (lives),
    .level_up   (level_up),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, seed A5.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 8'hA5;
    else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic logic [3:0] hit_vec(input hk_e k, input logic [1:0] t);
    logic [3:0] one;
    one = 4'b0001;
    case (k)
      HOK:     hit_vec = one << t;
      HWR:     hit_vec = one << (t + 2'd1);
      HMU:     hit_vec = (one << t) | (one << (t + 2'd2));
      default: hit_vec = 4'b0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".difficulty"}, 32'(difficulty), 0);
    chk({nm, ".target"}, 32'(target), 0);
    chk({nm, ".target_vld"}, 32'(target_vld), 0);
    chk({nm, ".score"}, 32'(score), 0);
    chk({nm, ".lives"}, 32'(lives), 0);
    chk({nm, ".level_up"}, 32'(level_up), 0);
    chk({nm, ".game_over"}, 32'(game_over), 0);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    logic [1:0] cand;
    @(negedge clk);
    start = v.start;
    tick  = v.tick;
    hit   = hit_vec(v.hk, exp_tgt);
    cand  = m_lfsr[1:0];
    @(posedge clk);
    #1;
    start = 1'b0;
    tick  = 1'b0;
    hit   = 4'b0000;
    if (v.vld && !prev_vld) exp_tgt = cand;
    prev_vld = v.vld;
    chk({nm, ".vld"}, 32'(target_vld), 32'(v.vld));
    chk({nm, ".score"}, 32'(score), 32'(v.score));
    chk({nm, ".lives"}, 32'(lives), 32'(v.lives));
    chk({nm, ".diff"}, 32'(difficulty), 32'(v.diff));
    chk({nm, ".level_up"}, 32'(level_up), 32'(v.lu));
    chk({nm, ".over"}, 32'(game_over), 32'(v.over));
    if (v.vld) chk({nm, ".target"}, 32'(target), 32'(exp_tgt));
  endtask

  function automatic vec_t mk(input logic s, input logic t, input hk_e k, input logic vl,
                              input logic [7:0] sc, input logic [2:0] li, input logic [2:0] df,
                              input logic lu, input logic ov);
    vec_t v;
    v.start = s; v.tick = t; v.hk = k; v.vld = vl; v.score = sc;
    v.lives = li; v.diff = df; v.lu = lu; v.over = ov;
    return v;
  endfunction

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_zero(nm);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    prev_vld = 1'b0;
    exp_tgt  = 2'd0;
  endtask

  // Fixed stimulus after reset; targets must follow the reseeded LFSR.
  task automatic seq_run(input string nm);
    for (int k = 0; k < 3; k++) run_vec(mk(0, 0, HN, 0, 0, 0, 0, 0, 0), {nm, ".idle"});
    run_vec(mk(1, 0, HN, 0, 0, 3, 0, 0, 0), {nm, ".start"});
    for (int k = 0; k < 3; k++) begin
      run_vec(mk(0, 1, HN, 1, 8'(k), 3, 0, 0, 0), $sformatf("%s.tick%0d", nm, k));
      run_vec(mk(0, 0, HOK, 0, 8'(k + 1), 3, 0, 0, 0), $sformatf("%s.hit%0d", nm, k));
    end
  endtask

  vec_t vecs[20];

  initial begin
    vecs[0]  = mk(1, 0, HN,  0, 0, 3, 0, 0, 0);  // start
    vecs[1]  = mk(0, 0, HN,  0, 0, 3, 0, 0, 0);
    vecs[2]  = mk(0, 0, HOK, 0, 0, 3, 0, 0, 0);  // hit in WAIT ignored
    vecs[3]  = mk(0, 1, HN,  1, 0, 3, 0, 0, 0);  // tick -> lit
    vecs[4]  = mk(0, 0, HN,  1, 0, 3, 0, 0, 0);
    vecs[5]  = mk(0, 0, HOK, 0, 1, 3, 0, 0, 0);  // correct hit
    vecs[6]  = mk(0, 1, HN,  1, 1, 3, 0, 0, 0);
    vecs[7]  = mk(0, 0, HWR, 0, 1, 2, 0, 0, 0);  // wrong button
    vecs[8]  = mk(0, 1, HN,  1, 1, 2, 0, 0, 0);
    vecs[9]  = mk(0, 1, HN,  1, 1, 2, 0, 0, 0);  // window 2 -> 1
    vecs[10] = mk(0, 1, HN,  0, 1, 1, 0, 0, 0);  // timeout miss
    vecs[11] = mk(0, 1, HN,  1, 1, 1, 0, 0, 0);
    vecs[12] = mk(1, 0, HN,  1, 1, 1, 0, 0, 0);  // start in SHOW ignored
    vecs[13] = mk(0, 1, HN,  1, 1, 1, 0, 0, 0);
    vecs[14] = mk(0, 1, HOK, 0, 2, 1, 0, 0, 0);  // hit beats final tick
    vecs[15] = mk(0, 1, HN,  1, 2, 1, 0, 0, 0);
    vecs[16] = mk(0, 0, HMU, 0, 2, 0, 0, 0, 1);  // multi-button -> last life
    vecs[17] = mk(0, 1, HN,  0, 2, 0, 0, 0, 1);  // tick in OVER ignored
    vecs[18] = mk(0, 0, HOK, 0, 2, 0, 0, 0, 1);  // hit in OVER ignored
    vecs[19] = mk(1, 0, HN,  0, 0, 3, 0, 0, 0);  // restart

    repeat (3) @(negedge clk);
    #1;
    chk_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // 24 correct hits: level every 4, capped at 4 (reached at 16).
    for (int i = 1; i <= 24; i++) begin
      int dprev, dnow;
      logic lu;
      dprev = ((i - 1) / 4 > 4) ? 4 : (i - 1) / 4;
      dnow  = (i / 4 > 4) ? 4 : i / 4;
      lu    = (i % 4 == 0) && (i <= 16);
      run_vec(mk(0, 1, HN, 1, 8'(i - 1), 3, 3'(dprev), 0, 0), $sformatf("lvl_tick%0d", i));
      run_vec(mk(0, 0, HOK, 0, 8'(i), 3, 3'(dnow), lu, 0), $sformatf("lvl_hit%0d", i));
    end

    // Reset while the lamp is lit, then reproduce the same sequence twice.
    run_vec(mk(0, 1, HN, 1, 24, 3, 4, 0, 0), "pre_rst_show");
    do_reset("rst_show");
    seq_run("runA");
    run_vec(mk(0, 1, HN, 1, 3, 3, 0, 0, 0), "pre_rst2");
    do_reset("rst_show2");
    seq_run("runB");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
